// File: rtl/adc_emulator.sv
// ---------------------------------------------------------------------------
// adc_emulator
//   ADC-side responder for the serial ADC read protocol. While cs_n is low it
//   shifts out one generated sample per frame on sdata, MSB first. The sample
//   is framed by leading and trailing zeros. sdata changes after sclk falling
//   edges, which are detected in the clk domain.
//
//   Optional build macro: ADC_EMULATOR_SYNC_EN
//     defined   - sclk/cs_n pass through 2-flop synchronizers first
//                 (asynchronous source allowed, minimum sclk half-period 5 clk)
//     undefined - single input register (minimum sclk half-period 3 clk)
// ---------------------------------------------------------------------------
module adc_emulator #(
   parameter int          FRAME_BITS = 16,
   parameter int          LEAD_ZEROS = 4,
   parameter int          DATA_BITS  = 8,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sclk,
   input  logic                 cs_n,
   input  logic [1:0]           pattern_mode,
   input  logic [DATA_BITS-1:0] pattern_value,
   output logic                 sdata,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 frame_aborted,
   output logic [15:0]          frame_count
);

   localparam int IDX_W = $clog2(FRAME_BITS + 1);
   localparam int TRAIL = FRAME_BITS - LEAD_ZEROS - DATA_BITS;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   localparam logic [1:0] MODE_FIXED = 2'b00;
   localparam logic [1:0] MODE_INC   = 2'b01;
   localparam logic [1:0] MODE_LFSR  = 2'b10;
   localparam logic [1:0] MODE_ALT   = 2'b11;

   // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   logic                  sclk_in_s;
   logic                  cs_n_in_s;
   logic                  sclk_cur_r;
   logic                  sclk_prev_r;
   logic                  cs_n_cur_r;
   logic                  cs_n_prev_r;
   logic                  sclk_fall_s;
   logic                  cs_fall_s;
   logic                  cs_rise_s;

   logic [1:0]            state_r;
   logic [1:0]            state_s;
   logic [IDX_W-1:0]      bit_idx_r;
   logic [IDX_W-1:0]      bit_idx_s;
   logic [FRAME_BITS-1:0] shreg_r;
   logic [FRAME_BITS-1:0] shreg_s;
   logic                  sdata_s;
   logic                  done_s;
   logic                  abort_s;
   logic                  advance_s;

   logic [DATA_BITS-1:0]  inc_r;
   logic [15:0]           lfsr_r;
   logic                  toggle_r;
   logic [DATA_BITS-1:0]  sample_s;
   logic [FRAME_BITS-1:0] frame_word_s;

   logic                  sdata_r;
   logic                  busy_r;
   logic                  frame_done_r;
   logic                  frame_aborted_r;
   logic [15:0]           frame_count_r;

`ifdef ADC_EMULATOR_SYNC_EN
   logic [1:0] sclk_sync_r;
   logic [1:0] cs_n_sync_r;

   // Two-flop synchronizers for an asynchronous sclk/cs_n source.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync_r <= 2'b11;
         cs_n_sync_r <= 2'b11;
      end else begin
         sclk_sync_r <= {sclk_sync_r[0], sclk};
         cs_n_sync_r <= {cs_n_sync_r[0], cs_n};
      end
   end

   assign sclk_in_s = sclk_sync_r[1];
   assign cs_n_in_s = cs_n_sync_r[1];
`else
   assign sclk_in_s = sclk;
   assign cs_n_in_s = cs_n;
`endif

   // Input register plus previous-value register for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_cur_r  <= 1'b1;
         sclk_prev_r <= 1'b1;
         cs_n_cur_r  <= 1'b1;
         cs_n_prev_r <= 1'b1;
      end else begin
         sclk_cur_r  <= sclk_in_s;
         sclk_prev_r <= sclk_cur_r;
         cs_n_cur_r  <= cs_n_in_s;
         cs_n_prev_r <= cs_n_cur_r;
      end
   end

   assign sclk_fall_s = sclk_prev_r & ~sclk_cur_r;
   assign cs_fall_s   = cs_n_prev_r & ~cs_n_cur_r;
   assign cs_rise_s   = ~cs_n_prev_r & cs_n_cur_r;

   // Sample selection from the current pattern mode and generator state.
   always_comb begin
      sample_s = pattern_value;
      case (pattern_mode)
         MODE_FIXED: sample_s = pattern_value;
         MODE_INC:   sample_s = inc_r;
         MODE_LFSR:  sample_s = lfsr_r[15 -: DATA_BITS];
         MODE_ALT:   sample_s = {DATA_BITS{toggle_r}};
         default:    sample_s = pattern_value;
      endcase
      frame_word_s = FRAME_BITS'(sample_s) << TRAIL;
   end

   // Frame FSM: cs_n edges take priority over sclk edges; sdata is the next
   // registered value so it tracks the bit selected by the new bit index.
   always_comb begin
      state_s   = state_r;
      bit_idx_s = bit_idx_r;
      shreg_s   = shreg_r;
      sdata_s   = 1'b0;
      done_s    = 1'b0;
      abort_s   = 1'b0;
      advance_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cs_fall_s) begin
               state_s   = ST_SHIFT;
               bit_idx_s = {IDX_W{1'b0}};
               shreg_s   = frame_word_s;
               sdata_s   = frame_word_s[FRAME_BITS-1];
            end else begin
               sdata_s   = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (cs_rise_s) begin
               state_s = ST_IDLE;
               abort_s = 1'b1;
            end else if (sclk_fall_s) begin
               if (bit_idx_r == IDX_W'(FRAME_BITS - 1)) begin
                  state_s   = ST_HOLD;
                  done_s    = 1'b1;
                  advance_s = 1'b1;
                  sdata_s   = 1'b0;
               end else begin
                  bit_idx_s = bit_idx_r + IDX_W'(1);
                  shreg_s   = {shreg_r[FRAME_BITS-2:0], 1'b0};
                  sdata_s   = shreg_r[FRAME_BITS-2];
               end
            end else begin
               sdata_s = shreg_r[FRAME_BITS-1];
            end
         end
         ST_HOLD: begin
            if (cs_rise_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r         <= ST_IDLE;
         bit_idx_r       <= {IDX_W{1'b0}};
         shreg_r         <= {FRAME_BITS{1'b0}};
         sdata_r         <= 1'b0;
         busy_r          <= 1'b0;
         frame_done_r    <= 1'b0;
         frame_aborted_r <= 1'b0;
      end else begin
         state_r         <= state_s;
         bit_idx_r       <= bit_idx_s;
         shreg_r         <= shreg_s;
         sdata_r         <= sdata_s;
         busy_r          <= (state_s == ST_SHIFT);
         frame_done_r    <= done_s;
         frame_aborted_r <= abort_s;
      end
   end

   // Frame counter and pattern generators advance only on completed frames.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_count_r <= 16'd0;
         inc_r         <= {DATA_BITS{1'b0}};
         lfsr_r        <= LFSR_SEED;
         toggle_r      <= 1'b0;
      end else if (advance_s) begin
         frame_count_r <= frame_count_r + 16'd1;
         inc_r         <= inc_r + DATA_BITS'(1);
         lfsr_r        <= lfsr_step(lfsr_r);
         toggle_r      <= ~toggle_r;
      end
   end

   assign sdata         = sdata_r;
   assign busy          = busy_r;
   assign frame_done    = frame_done_r;
   assign frame_aborted = frame_aborted_r;
   assign frame_count   = frame_count_r;

endmodule

// File: tb/tb_adc_emulator.sv
// ---------------------------------------------------------------------------
// tb_adc_emulator
//   Directed, table-driven bench for adc_emulator with default parameters.
//   sclk idles low; each pulse is HP clk high then HP clk low.
// ---------------------------------------------------------------------------
module tb_adc_emulator;

   localparam int HP = 3;

   logic        clk;
   logic        reset;
   logic        sclk;
   logic        cs_n;
   logic [1:0]  pattern_mode;
   logic [7:0]  pattern_value;
   logic        sdata;
   logic        busy;
   logic        frame_done;
   logic        frame_aborted;
   logic [15:0] frame_count;

   int total;
   int bad;
   int done_cnt;
   int abort_cnt;

   typedef struct {
      logic        do_rst;
      logic [1:0]  mode;
      logic [7:0]  value;
      int          pulses;
      logic [15:0] exp_word;
      int          exp_done;
      int          exp_abort;
      logic [15:0] exp_count;
   } vec_t;

   vec_t vecs [12];

   adc_emulator dut (
      .clk           (clk),
      .reset         (reset),
      .sclk          (sclk),
      .cs_n          (cs_n),
      .pattern_mode  (pattern_mode),
      .pattern_value (pattern_value),
      .sdata         (sdata),
      .busy          (busy),
      .frame_done    (frame_done),
      .frame_aborted (frame_aborted),
      .frame_count   (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count clk cycles with each pulse output high.
   always @(negedge clk) begin
      if (frame_done)    done_cnt  <= done_cnt + 1;
      if (frame_aborted) abort_cnt <= abort_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sclk_pulse();
      sclk = 1'b1;
      wait_clk(HP);
      sclk = 1'b0;
      wait_clk(HP);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cs_n  = 1'b1;
      sclk  = 1'b0;
      wait_clk(2);
      reset = 1'b0;
      wait_clk(2);
   endtask

   // One frame: collect the bit shown before each of the first 16 falls,
   // and require sdata low and busy low once the 16th fall has happened.
   task automatic run_frame(input int npulses, output logic [15:0] word);
      word = 16'h0000;
      cs_n = 1'b0;
      wait_clk(HP);
      word[15] = sdata;
      for (int p = 1; p <= npulses; p++) begin
         sclk_pulse();
         if (p == 1) check("busy_in_frame", {31'd0, busy}, 32'd1);
         if (p < 16) begin
            word[15-p] = sdata;
         end else begin
            check("sdata_after_last", {31'd0, sdata}, 32'd0);
            if (p == 16) check("busy_after_last", {31'd0, busy}, 32'd0);
         end
      end
      cs_n = 1'b1;
      wait_clk(HP);
   endtask

   initial begin
      logic [15:0] w;
      int d0;
      int a0;
      logic [15:0] c0;

      total = 0; bad = 0; done_cnt = 0; abort_cnt = 0;
      reset = 1'b1; sclk = 1'b0; cs_n = 1'b1;
      pattern_mode = 2'b00; pattern_value = 8'h00;

      //            rst   mode   value  pls  word      done abort count
      vecs[0]  = '{1'b1, 2'b00, 8'hA5, 16, 16'h0A50, 1, 0, 16'd1};
      vecs[1]  = '{1'b1, 2'b01, 8'h00, 16, 16'h0000, 1, 0, 16'd1};
      vecs[2]  = '{1'b0, 2'b01, 8'h00, 16, 16'h0010, 1, 0, 16'd2};
      vecs[3]  = '{1'b0, 2'b01, 8'h00, 16, 16'h0020, 1, 0, 16'd3};
      vecs[4]  = '{1'b1, 2'b10, 8'h00, 16, 16'h0AC0, 1, 0, 16'd1};
      vecs[5]  = '{1'b0, 2'b10, 8'h00, 16, 16'h0590, 1, 0, 16'd2};
      vecs[6]  = '{1'b0, 2'b11, 8'h00, 16, 16'h0000, 1, 0, 16'd3};
      vecs[7]  = '{1'b0, 2'b11, 8'h00, 16, 16'h0FF0, 1, 0, 16'd4};
      vecs[8]  = '{1'b0, 2'b01, 8'h00, 16, 16'h0040, 1, 0, 16'd5};
      vecs[9]  = '{1'b0, 2'b01, 8'h00,  7, 16'h0000, 0, 1, 16'd5};
      vecs[10] = '{1'b0, 2'b01, 8'h00, 16, 16'h0050, 1, 0, 16'd6};
      vecs[11] = '{1'b0, 2'b00, 8'h3C, 20, 16'h03C0, 1, 0, 16'd7};

      // Reset state
      do_reset();
      check("rst_sdata", {31'd0, sdata}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, frame_done}, 32'd0);
      check("rst_abort", {31'd0, frame_aborted}, 32'd0);
      check("rst_count", {16'd0, frame_count}, 32'd0);

      // Table-driven frames
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].do_rst) do_reset();
         pattern_mode  = vecs[i].mode;
         pattern_value = vecs[i].value;
         d0 = done_cnt;
         a0 = abort_cnt;
         run_frame(vecs[i].pulses, w);
         check($sformatf("v%0d_word", i), {16'd0, w}, {16'd0, vecs[i].exp_word});
         check($sformatf("v%0d_done", i), done_cnt - d0, vecs[i].exp_done);
         check($sformatf("v%0d_abort", i), abort_cnt - a0, vecs[i].exp_abort);
         check($sformatf("v%0d_count", i), {16'd0, frame_count}, {16'd0, vecs[i].exp_count});
      end

      // cs_n fall together with an sclk fall: that sclk edge does not count
      pattern_mode = 2'b00; pattern_value = 8'hFF;
      sclk = 1'b1;
      wait_clk(HP);
      d0 = done_cnt;
      sclk = 1'b0; cs_n = 1'b0;
      wait_clk(HP);
      check("sim_fall_busy", {31'd0, busy}, 32'd1);
      for (int p = 0; p < 15; p++) sclk_pulse();
      check("sim_fall_no_early_done", done_cnt - d0, 32'd0);
      check("sim_fall_busy15", {31'd0, busy}, 32'd1);
      sclk_pulse();
      check("sim_fall_done16", done_cnt - d0, 32'd1);
      check("sim_fall_count", {16'd0, frame_count}, 32'd8);
      cs_n = 1'b1;
      wait_clk(HP);

      // cs_n rise together with the 16th sclk fall: abort wins
      d0 = done_cnt; a0 = abort_cnt; c0 = frame_count;
      cs_n = 1'b0;
      wait_clk(HP);
      for (int p = 0; p < 15; p++) sclk_pulse();
      sclk = 1'b1;
      wait_clk(HP);
      sclk = 1'b0; cs_n = 1'b1;
      wait_clk(HP);
      check("sim_rise_abort", abort_cnt - a0, 32'd1);
      check("sim_rise_no_done", done_cnt - d0, 32'd0);
      check("sim_rise_count", {16'd0, frame_count}, {16'd0, c0});
      check("sim_rise_busy", {31'd0, busy}, 32'd0);

      // Reset asserted mid-frame
      pattern_mode = 2'b01;
      cs_n = 1'b0;
      wait_clk(HP);
      for (int p = 0; p < 5; p++) sclk_pulse();
      d0 = done_cnt; a0 = abort_cnt;
      reset = 1'b1; cs_n = 1'b1;
      wait_clk(1);
      reset = 1'b0;
      check("midrst_sdata", {31'd0, sdata}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_count", {16'd0, frame_count}, 32'd0);
      wait_clk(HP);
      check("midrst_no_pulses", (done_cnt - d0) + (abort_cnt - a0), 32'd0);
      run_frame(16, w);
      check("midrst_first_word", {16'd0, w}, 32'h0000);
      check("midrst_first_count", {16'd0, frame_count}, 32'd1);

      // Increment counter wrap: 256 frames then 0x00 again
      do_reset();
      pattern_mode = 2'b01;
      for (int f = 0; f < 256; f++) run_frame(16, w);
      check("wrap_last_word", {16'd0, w}, 32'h0FF0);
      check("wrap_count256", {16'd0, frame_count}, 32'd256);
      run_frame(16, w);
      check("wrap_next_word", {16'd0, w}, 32'h0000);
      check("wrap_count257", {16'd0, frame_count}, 32'd257);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
